// File: rtl/div_int_arbiter.sv
// Round-robin front end sharing one iterative div_int among NUM_REQ requesters.
// Optional macro DIV_INT_ARB_ZERO_BYPASS_EN answers divisor==0 without starting the divider.

module div_int #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  opcode,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  valid_out,
    output logic                  almost_valid,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {D_IDLE, D_ITER, D_FIX} dphase_e;

    dphase_e               phase_q, phase_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] part_q, part_d, quo_q, quo_d;
    logic [DATA_WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic                  valid_q, valid_d;
    logic                  neg_a, neg_b;
    logic [DATA_WIDTH-1:0] abs_a, abs_b;
    logic [DATA_WIDTH:0]   shifted, trial;

    // Operands are read live every cycle, so the caller must hold them until valid_out.
    assign neg_a   = opcode & dividend[DATA_WIDTH-1];
    assign neg_b   = opcode & divisor[DATA_WIDTH-1];
    assign abs_a   = neg_a ? -dividend : dividend;
    assign abs_b   = neg_b ? -divisor  : divisor;
    assign shifted = {part_q, quo_q[DATA_WIDTH-1]};
    assign trial   = shifted - {1'b0, abs_b};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q <= D_IDLE;
            cnt_q   <= '0;
            part_q  <= '0;
            quo_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            quo_q   <= quo_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            D_IDLE:  if (en) phase_d = D_ITER;
            D_ITER:  if (cnt_q == CW'(DATA_WIDTH-1)) phase_d = D_FIX;
            default: phase_d = D_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        part_d  = part_q;
        quo_d   = quo_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        valid_d = 1'b0;
        case (phase_q)
            D_IDLE: if (en) begin
                cnt_d  = '0;
                part_d = '0;
                quo_d  = abs_a;
            end
            D_ITER: begin
                cnt_d = cnt_q + 1'b1;
                if (shifted >= {1'b0, abs_b}) begin
                    part_d = trial[DATA_WIDTH-1:0];
                    quo_d  = {quo_q[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    part_d = shifted[DATA_WIDTH-1:0];
                    quo_d  = {quo_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
            default: begin
                quot_d  = (neg_a ^ neg_b) ? -quo_q : quo_q;
                rem_d   = neg_a ? -part_q : part_q;
                valid_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        valid_out    = valid_q;
        almost_valid = (phase_q == D_FIX);
        quotient     = quot_q;
        remainder    = rem_q;
    end
endmodule

module div_int_arbiter #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REQ    = 4,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_opcode,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_WIDTH-1:0]           resp_id,
    output logic [DATA_WIDTH-1:0]         resp_quotient,
    output logic [DATA_WIDTH-1:0]         resp_remainder,
    output logic                          busy
);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  op_opc_q, op_opc_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [ID_WIDTH-1:0]   op_id_q, op_id_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;
    logic [DATA_WIDTH-1:0] resp_quo_q, resp_quo_d, resp_rem_q, resp_rem_d;

    logic                  grant_found, can_grant, hs, bypass_zero, div_en;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [DATA_WIDTH-1:0] sel_a, sel_b;
    logic                  div_valid, div_almost_valid;
    logic [DATA_WIDTH-1:0] div_quo, div_rem;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(idx);
            end
        end
    end

    assign sel_a     = req_dividend[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_b     = req_divisor[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign can_grant = (state_q == S_IDLE) && (!resp_valid_q || resp_ready) && !reset;
    assign hs        = can_grant && grant_found;

`ifdef DIV_INT_ARB_ZERO_BYPASS_EN
    assign bypass_zero = (sel_b == '0);
`else
    assign bypass_zero = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_quo_q   <= '0;
            resp_rem_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_quo_q   <= resp_quo_d;
            resp_rem_q   <= resp_rem_d;
        end
    end

    // Operand registers carry no reset; they are only meaningful after a grant.
    always_ff @(posedge clock) begin
        op_opc_q <= op_opc_d;
        op_a_q   <= op_a_d;
        op_b_q   <= op_b_d;
        op_id_q  <= op_id_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (hs && !bypass_zero) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   if (div_valid) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (hs) req_ready[grant_idx] = 1'b1;
        busy   = (state_q == S_LAUNCH) || (state_q == S_WAIT);
        div_en = (state_q == S_LAUNCH);
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        op_opc_d     = op_opc_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_id_d      = op_id_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_quo_d   = resp_quo_q;
        resp_rem_d   = resp_rem_q;
        if (resp_valid_q && resp_ready) resp_valid_d = 1'b0;
        if (hs) begin
            rr_ptr_d = (int'(grant_idx) == NUM_REQ-1) ? '0 : grant_idx + 1'b1;
            op_opc_d = req_opcode[grant_idx];
            op_a_d   = sel_a;
            op_b_d   = sel_b;
            op_id_d  = grant_idx;
        end
        // Grant gating guarantees the buffer is free whenever either load fires.
        if (hs && bypass_zero) begin
            resp_valid_d = 1'b1;
            resp_id_d    = grant_idx;
            resp_quo_d   = '1;
            resp_rem_d   = sel_a;
        end else if (state_q == S_WAIT && div_valid) begin
            resp_valid_d = 1'b1;
            resp_id_d    = op_id_q;
            resp_quo_d   = div_quo;
            resp_rem_d   = div_rem;
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_id        = resp_id_q;
    assign resp_quotient  = resp_quo_q;
    assign resp_remainder = resp_rem_q;

    div_int #(.DATA_WIDTH(DATA_WIDTH)) u_div (
        .clock        (clock),
        .reset        (reset),
        .en           (div_en),
        .opcode       (op_opc_q),
        .dividend     (op_a_q),
        .divisor      (op_b_q),
        .valid_out    (div_valid),
        .almost_valid (div_almost_valid),
        .quotient     (div_quo),
        .remainder    (div_rem)
    );
endmodule

// File: tb/tb_div_int_arbiter.sv
// Randomized self-checking bench for div_int_arbiter against a queue-based reference model.
module tb_div_int_arbiter;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid, req_ready, req_opcode;
    logic [NR*DW-1:0]  req_dividend, req_divisor;
    logic              resp_valid, resp_ready, busy;
    logic [IW-1:0]     resp_id;
    logic [DW-1:0]     resp_quotient, resp_remainder;

    always #5 clock = ~clock;

    div_int_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_quotient(resp_quotient), .resp_remainder(resp_remainder), .busy(busy)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        int            t;
        int            lat;
    } exp_t;

    int   n_chk = 0, n_err = 0, cyc = 0;
    exp_t eq[$];
    int   gl[$];
    int   mptr = 0;
    logic pv = 1'b0, pdr = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*DW-1:0] ref_div(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [DW-1:0] sa, sb;
        sa = a; sb = b;
        if (b == '0) return {{DW{1'b1}}, a};
        if (op) return {DW'(sa / sb), DW'(sa % sb)};
        return {a / b, a % b};
    endfunction

    // Reference: responses come back in grant order; grant index follows round-robin from mptr.
    always @(negedge clock) begin
        exp_t e;
        int   idx, eidx;
        logic [2*DW-1:0] qr;
        logic [DW-1:0] b;
        if (reset) begin
            eq.delete(); mptr = 0; pv = 1'b0; pdr = 1'b0;
        end else begin
            if (resp_valid) begin
                if (eq.size() == 0) chk("unexpected_resp", 1, 0);
                else begin
                    e = eq[0];
                    if (!pv || pdr) chk("latency", cyc - e.t, e.lat);
                    chk("resp_id", resp_id, e.id);
                    chk("resp_q", resp_quotient, e.q);
                    chk("resp_r", resp_remainder, e.r);
                    if (resp_ready) void'(eq.pop_front());
                end
            end
            pv  = resp_valid;
            pdr = resp_valid && resp_ready;
            if (req_ready != '0) begin
                chk("ready_onehot", $countones(req_ready), 1);
                idx = 0; eidx = -1;
                for (int k = NR-1; k >= 0; k--) if (req_ready[k]) idx = k;
                for (int k = 0; k < NR; k++)
                    if (eidx < 0 && req_valid[(mptr+k)%NR]) eidx = (mptr+k)%NR;
                chk("ready_has_valid", req_valid[idx], 1);
                chk("rr_idx", idx, eidx);
                mptr = (idx + 1) % NR;
                b  = req_divisor[idx*DW +: DW];
                qr = ref_div(req_opcode[idx], req_dividend[idx*DW +: DW], b);
                e.id = IW'(idx); e.q = qr[2*DW-1:DW]; e.r = qr[DW-1:0]; e.t = cyc;
`ifdef DIV_INT_ARB_ZERO_BYPASS_EN
                e.lat = (b == '0) ? 1 : DW + 4;
`else
                e.lat = DW + 4;
`endif
                eq.push_back(e);
                gl.push_back(idx);
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic set_req(input int i, input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_valid[i] = 1'b1;
        req_opcode[i] = op;
        req_dividend[i*DW +: DW] = a;
        req_divisor[i*DW +: DW] = b;
    endtask

    task automatic wait_hs(input int i, output int waited);
        waited = 0;
        forever begin
            @(negedge clock);
            if (req_ready[i]) break;
            waited++;
            if (waited > 600) begin chk("hs_timeout", 0, 1); break; end
        end
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clock);
            if (eq.size() == 0 && !resp_valid && !busy) break;
            n++;
            if (n > 3000) begin chk("idle_timeout", 0, 1); break; end
        end
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clock);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_rvalid"}, resp_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rid"}, resp_id, 0);
        chk({tag, "_rq"}, resp_quotient, 0);
        chk({tag, "_rr"}, resp_remainder, 0);
    endtask

    initial begin
        int w, cnt, nops, guard;
        int rot_exp[5];
        logic [DW-1:0] snap_q, snap_r, a, b;
        logic [NR-1:0] hs;
        logic op;

        reset = 1'b1; resp_ready = 1'b1;
        req_valid = '1; req_opcode = '0;
        req_dividend = {NR{32'd50}}; req_divisor = {NR{32'd5}};
        check_reset_outputs("rst");
        tick();
        req_valid = '0; reset = 1'b0;
        tick();

        // Unsigned 100/7 from requester 2
        set_req(2, 1'b0, 32'd100, 32'd7);
        wait_hs(2, w);
        wait_idle();

        // Signed -100/7 from requester 0; scramble its inputs after the handshake
        set_req(0, 1'b1, -32'sd100, 32'd7);
        wait_hs(0, w);
        req_opcode[0] = 1'b0;
        req_dividend[0 +: DW] = 32'hDEAD_BEEF;
        req_divisor[0 +: DW]  = 32'h0000_0003;
        wait_idle();

        // Fresh pointer, all requesters valid continuously
        reset = 1'b1; tick(); reset = 1'b0; tick();
        gl.delete();
        for (int i = 0; i < NR; i++) set_req(i, i[0], 32'd1000 + 32'(i*37), 32'(i + 3));
        guard = 0;
        while (gl.size() < 5 && guard < 400) begin @(negedge clock); guard++; end
        tick();
        req_valid = '0;
        rot_exp = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) chk("rot_order", (k < gl.size()) ? gl[k] : -1, rot_exp[k]);
        wait_idle();

        // Response back-pressure: requester 1 then 3 (pointer sits at 1)
        resp_ready = 1'b0;
        set_req(1, 1'b0, 32'd777, 32'd10);
        set_req(3, 1'b0, 32'd123456, 32'd1000);
        wait_hs(1, w);
        guard = 0;
        while (!resp_valid && guard < 100) begin @(negedge clock); guard++; end
        chk("stall_resp_seen", resp_valid, 1);
        snap_q = resp_quotient; snap_r = resp_remainder;
        cnt = 0;
        repeat (100) begin @(negedge clock); if (req_ready != '0) cnt++; end
        chk("stall_no_ready", cnt, 0);
        chk("stall_q_stable", resp_quotient, snap_q);
        chk("stall_r_stable", resp_remainder, snap_r);
        @(posedge clock); #1 resp_ready = 1'b1;
        @(negedge clock);
        chk("release_grant", req_ready, 4'b1000);
        tick();
        req_valid[3] = 1'b0;
        wait_idle();

        // Reset 10 cycles into the divider run
        set_req(1, 1'b0, 32'd1000, 32'd7);
        wait_hs(1, w);
        repeat (10) tick();
        reset = 1'b1;
        req_valid = '1;
        check_reset_outputs("midrst");
        tick();
        req_valid = '0; reset = 1'b0;
        cnt = 0;
        repeat (DW + 10) begin @(negedge clock); if (resp_valid) cnt++; end
        chk("abandoned_no_resp", cnt, 0);
        tick();
        set_req(0, 1'b0, 32'd9, 32'd3);
        wait_hs(0, w);
        chk("post_reset_first_grant", w, 0);
        wait_idle();

        // Zero divisor
        set_req(2, 1'b0, 32'd55, 32'd0);
        wait_hs(2, w);
        cnt = 0;
        repeat (DW + 6) begin @(negedge clock); if (busy) cnt++; end
`ifdef DIV_INT_ARB_ZERO_BYPASS_EN
        chk("zero_no_busy", cnt, 0);
`else
        chk("zero_busy", cnt > 0, 1);
`endif
        wait_idle();

        // Random traffic
        nops = 0; guard = 0;
        while (nops < 150 && guard < 20000) begin
            @(negedge clock);
            hs = req_valid & req_ready;
            nops += $countones(hs);
            tick();
            guard++;
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || hs[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        op = 1'($urandom_range(0, 1));
                        a  = $urandom;
                        case ($urandom_range(0, 3))
                            0:       b = 32'($urandom_range(1, 20));
                            1:       b = -32'($urandom_range(1, 20));
                            2:       b = 32'd0;
                            default: b = $urandom;
                        endcase
                        if (op && b == '0) b = 32'd1;
                        if (op && a == 32'h8000_0000 && b == '1) b = 32'd1;
                        set_req(i, op, a, b);
                    end else req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
            end
        end
        chk("random_ops_done", nops >= 150, 1);
        req_valid = '0; resp_ready = 1'b1;
        wait_idle();
        chk("scoreboard_empty", eq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
